// File: rtl/mdu_issue_pkg.sv
// Shared definitions for the M-extension issue stage: funct3 codes, FSM states,
// datapath width and the 32->64 extension helpers.
package mdu_issue_pkg;

  localparam int XLEN = 32'd64;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    return {32'd0, v};
  endfunction

endpackage

// File: rtl/mdu_opprep.sv
// Combinational operand preparation and one-hot operation decode for the MDU.
module mdu_opprep
  import mdu_issue_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic [XLEN-1:0] src1_prep,
  output logic [XLEN-1:0] src2_prep,
  output logic [7:0]      op_onehot,
  output logic            illegal
);

  // Bit i of the select vector corresponds to funct3 == i.
  assign op_onehot = 8'b0000_0001 << funct3;

  // Word variants extend the low halves; the high-half multiplies have no W form.
  always_comb begin
    src1_prep = src1;
    src2_prep = src2;
    illegal   = 1'b0;
    if (word) begin
      case (funct3_e'(funct3))
        F3_MUL, F3_DIV, F3_REM: begin
          src1_prep = sext32(src1[31:0]);
          src2_prep = sext32(src2[31:0]);
        end
        F3_DIVU, F3_REMU: begin
          src1_prep = zext32(src1[31:0]);
          src2_prep = zext32(src2[31:0]);
        end
        default: illegal = 1'b1;
      endcase
    end else begin
      src1_prep = src1;
      src2_prep = src2;
    end
  end

endmodule

// File: rtl/mdu_issue.sv
// Issue stage between the pipeline and a multi-cycle multiply/divide unit, with
// a single-entry last-result reuse store and pipeline-flush handling.
module mdu_issue
  import mdu_issue_pkg::*;
#(
  parameter int TAG_W    = 32'd5,
  parameter bit REUSE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic             in_word,
  input  logic [63:0]      in_src1,
  input  logic [63:0]      in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             mdu_mul,
  output logic             mdu_mulh,
  output logic             mdu_mulhu,
  output logic             mdu_mulhsu,
  output logic             mdu_div,
  output logic             mdu_divu,
  output logic             mdu_rem,
  output logic             mdu_remu,
  output logic [63:0]      mdu_src1,
  output logic [63:0]      mdu_src2,
  output logic             mdu_flush,
  input  logic [63:0]      mdu_result,
  input  logic             mdu_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [TAG_W-1:0] out_tag
);

  state_e            state_r;
  logic [2:0]        funct3_r;
  logic              word_r;
  logic [7:0]        sel_r;
  logic [XLEN-1:0]   src1_r, src2_r, result_r;
  logic [TAG_W-1:0]  tag_r;
  logic              mdu_flush_r;

  logic              hit_valid_r;
  logic [2:0]        hit_funct3_r;
  logic              hit_word_r;
  logic [XLEN-1:0]   hit_src1_r, hit_src2_r, hit_result_r;

  logic [XLEN-1:0]   src1_prep_s, src2_prep_s, capture_s;
  logic [7:0]        onehot_s;
  logic              illegal_s, hit_s;

  mdu_opprep u_opprep (
    .funct3    (in_funct3),
    .word      (in_word),
    .src1      (in_src1),
    .src2      (in_src2),
    .src1_prep (src1_prep_s),
    .src2_prep (src2_prep_s),
    .op_onehot (onehot_s),
    .illegal   (illegal_s)
  );

  assign hit_s = REUSE_EN && hit_valid_r && (hit_funct3_r == in_funct3) &&
                 (hit_word_r == in_word) && (hit_src1_r == src1_prep_s) &&
                 (hit_src2_r == src2_prep_s);

  assign capture_s = word_r ? sext32(mdu_result[31:0]) : mdu_result;

  assign in_ready   = (state_r == ST_IDLE);
  assign out_valid  = (state_r == ST_DONE);
  assign {mdu_remu, mdu_rem, mdu_divu, mdu_div,
          mdu_mulhu, mdu_mulhsu, mdu_mulh, mdu_mul} = sel_r;
  assign mdu_src1   = src1_r;
  assign mdu_src2   = src2_r;
  assign mdu_flush  = mdu_flush_r;
  assign out_result = result_r;
  assign out_tag    = tag_r;

  // Issue FSM, operand/result registers and reuse store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      funct3_r     <= 3'd0;
      word_r       <= 1'b0;
      sel_r        <= 8'd0;
      src1_r       <= 64'd0;
      src2_r       <= 64'd0;
      result_r     <= 64'd0;
      tag_r        <= '0;
      mdu_flush_r  <= 1'b0;
      hit_valid_r  <= 1'b0;
      hit_funct3_r <= 3'd0;
      hit_word_r   <= 1'b0;
      hit_src1_r   <= 64'd0;
      hit_src2_r   <= 64'd0;
      hit_result_r <= 64'd0;
    end else begin
      mdu_flush_r <= flush && (state_r == ST_BUSY);
      if (flush) begin
        // A kill drops any request, in-flight result and the reuse entry.
        state_r     <= ST_IDLE;
        sel_r       <= 8'd0;
        hit_valid_r <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (in_valid) begin
              funct3_r <= in_funct3;
              word_r   <= in_word;
              src1_r   <= src1_prep_s;
              src2_r   <= src2_prep_s;
              tag_r    <= in_tag;
              if (illegal_s) begin
                result_r <= 64'd0;
                state_r  <= ST_DONE;
              end else if (hit_s) begin
                result_r <= hit_result_r;
                state_r  <= ST_DONE;
              end else begin
                sel_r    <= onehot_s;
                state_r  <= ST_BUSY;
              end
            end
          end
          ST_BUSY: begin
            if (mdu_ready) begin
              result_r     <= capture_s;
              sel_r        <= 8'd0;
              state_r      <= ST_DONE;
              hit_valid_r  <= REUSE_EN;
              hit_funct3_r <= funct3_r;
              hit_word_r   <= word_r;
              hit_src1_r   <= src1_r;
              hit_src2_r   <= src2_r;
              hit_result_r <= capture_s;
            end
          end
          ST_DONE: begin
            if (out_ready) begin
              state_r <= ST_IDLE;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            sel_r   <= 8'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_issue.sv
// Randomized self-checking bench for mdu_issue with a behavioural MDU and an
// architectural reference model of results, reuse and latency.
module tb_mdu_issue;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, in_word;
  logic [2:0]       in_funct3;
  logic [63:0]      in_src1, in_src2;
  logic [TAG_W-1:0] in_tag;
  logic             mdu_mul, mdu_mulh, mdu_mulhu, mdu_mulhsu;
  logic             mdu_div, mdu_divu, mdu_rem, mdu_remu;
  logic [63:0]      mdu_src1, mdu_src2, mdu_result;
  logic             mdu_flush, mdu_ready;
  logic             out_valid, out_ready;
  logic [63:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic [7:0]       sel_v;

  always #5 clk = ~clk;

  mdu_issue #(.TAG_W(TAG_W), .REUSE_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3), .in_word(in_word),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .mdu_mul(mdu_mul), .mdu_mulh(mdu_mulh), .mdu_mulhu(mdu_mulhu), .mdu_mulhsu(mdu_mulhsu),
    .mdu_div(mdu_div), .mdu_divu(mdu_divu), .mdu_rem(mdu_rem), .mdu_remu(mdu_remu),
    .mdu_src1(mdu_src1), .mdu_src2(mdu_src2), .mdu_flush(mdu_flush),
    .mdu_result(mdu_result), .mdu_ready(mdu_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag)
  );

  assign sel_v = {mdu_remu, mdu_rem, mdu_divu, mdu_div, mdu_mulhu, mdu_mulhsu, mdu_mulh, mdu_mul};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RV64 M-extension semantics on full 64-bit operands.
  function automatic logic [63:0] rv64(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] x1, x2, p;
    logic signed [63:0]  sa, sb, q;
    logic [127:0]        up;
    sa = a; sb = b;
    x1 = {{64{a[63]}}, a};
    case (f)
      3'd0: return a * b;
      3'd1: begin x2 = {{64{b[63]}}, b}; p = x1 * x2; return p[127:64]; end
      3'd2: begin x2 = {64'd0, b}; p = x1 * x2; return p[127:64]; end
      3'd3: begin up = {64'd0, a} * {64'd0, b}; return up[127:64]; end
      3'd4: begin
        if (b == 64'd0) return '1;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
        q = sa / sb; return q;
      end
      3'd5: return (b == 64'd0) ? '1 : a / b;
      3'd6: begin
        if (b == 64'd0) return a;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return 64'd0;
        q = sa % sb; return q;
      end
      default: return (b == 64'd0) ? a : a % b;
    endcase
  endfunction

  // RV64 *W semantics computed directly in 32-bit arithmetic.
  function automatic logic [63:0] rv32w(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0]        r;
    logic signed [31:0] sa, sb, q;
    sa = a; sb = b;
    case (f)
      3'd0: r = a * b;
      3'd4: begin
        if (b == 32'd0) r = '1;
        else if (a == 32'h8000_0000 && b == '1) r = a;
        else begin q = sa / sb; r = q; end
      end
      3'd5: r = (b == 32'd0) ? '1 : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == '1) r = 32'd0;
        else begin q = sa % sb; r = q; end
      end
      3'd7: r = (b == 32'd0) ? a : a % b;
      default: r = 32'd0;
    endcase
    return {{32{r[31]}}, r};
  endfunction

  // Behavioural MDU: answers after mdu_delay cycles of a held select.
  int mdu_delay = 3;
  int mdu_cnt   = 0;
  bit stray_en  = 0;

  function automatic logic [2:0] sel_index(input logic [7:0] s);
    for (int i = 0; i < 8; i++) if (s[i]) return 3'(i);
    return 3'd0;
  endfunction

  always @(negedge clk) begin
    if (sel_v != 8'd0 && !mdu_flush) begin
      if (mdu_cnt < mdu_delay) begin
        mdu_cnt++;
        if (mdu_cnt == mdu_delay) begin
          mdu_ready  = 1'b1;
          mdu_result = rv64(sel_index(sel_v), mdu_src1, mdu_src2);
        end else begin
          mdu_ready = 1'b0;
        end
      end
    end else begin
      mdu_cnt = 0;
      if (stray_en) begin
        mdu_ready  = 1'($urandom_range(1, 0));
        mdu_result = {$urandom, $urandom};
      end else begin
        mdu_ready  = 1'b0;
      end
    end
  end

  // Reference reuse entry: key is op, word bit and the operand bits that matter.
  bit          ref_valid = 0;
  logic [2:0]  ref_f3;
  bit          ref_w;
  logic [63:0] ref_a, ref_b, ref_res;

  function automatic bit key_match(input logic [2:0] f, input bit w, input logic [63:0] a, input logic [63:0] b);
    if (!ref_valid || f != ref_f3 || w != ref_w) return 0;
    if (w) return (a[31:0] == ref_a[31:0]) && (b[31:0] == ref_b[31:0]);
    return (a == ref_a) && (b == ref_b);
  endfunction

  task automatic do_op(input logic [2:0] f, input bit w, input logic [63:0] a, input logic [63:0] b,
                       input int delay, input int hold,
                       output logic [63:0] first_src1, output logic [63:0] got_res);
    bit               illegal, hit, used, unstable;
    logic [63:0]      exp_res, s1_0, s2_0;
    logic [7:0]       sel_obs;
    logic [TAG_W-1:0] tg;
    int               exp_lat, lat, guard;
    illegal = w && (f == 3'd1 || f == 3'd2 || f == 3'd3);
    hit     = !illegal && key_match(f, w, a, b);
    exp_res = illegal ? 64'd0 : hit ? ref_res : (w ? rv32w(f, a[31:0], b[31:0]) : rv64(f, a, b));
    exp_lat = (illegal || hit) ? 1 : delay + 1;
    tg = TAG_W'($urandom);
    mdu_delay = delay;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
    check_eq("in_ready_before_issue", in_ready, 1);
    in_valid = 1; in_funct3 = f; in_word = w; in_src1 = a; in_src2 = b; in_tag = tg;
    @(negedge clk);
    in_valid = 0; in_src1 = {$urandom, $urandom}; in_src2 = {$urandom, $urandom};
    lat = 1; used = 0; unstable = 0; sel_obs = 8'd0;
    first_src1 = mdu_src1; s1_0 = mdu_src1; s2_0 = mdu_src2;
    while (1) begin
      if (sel_v != 8'd0) begin
        used = 1; sel_obs = sel_v;
        if (mdu_src1 !== s1_0 || mdu_src2 !== s2_0) unstable = 1;
      end
      if (out_valid || lat >= 40) break;
      @(negedge clk);
      lat++;
    end
    got_res = out_result;
    check_eq("out_valid", out_valid, 1);
    check_eq("latency", 64'(lat), 64'(exp_lat));
    check_eq("result", out_result, exp_res);
    check_eq("tag", out_tag, 64'(tg));
    check_eq("sel_low_in_done", sel_v, 8'd0);
    if (illegal || hit) check_eq("no_mdu_access", used, 0);
    else begin
      check_eq("sel_onehot", sel_obs, 8'b1 << f);
      check_eq("src_stable", unstable, 0);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_result", out_result, exp_res);
      check_eq("hold_tag", out_tag, 64'(tg));
      check_eq("hold_in_ready", in_ready, 0);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check_eq("idle_after_out", in_ready, 1);
    check_eq("valid_drop", out_valid, 0);
    if (!illegal && !hit) begin
      ref_valid = 1; ref_f3 = f; ref_w = w; ref_a = a; ref_b = b; ref_res = exp_res;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 1);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_out_result"}, out_result, 0);
    check_eq({tag, "_out_tag"}, out_tag, 0);
    check_eq({tag, "_sel"}, sel_v, 0);
    check_eq({tag, "_src"}, mdu_src1 | mdu_src2, 0);
    check_eq({tag, "_mdu_flush"}, mdu_flush, 0);
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(5, 0))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(20, 0));
      4: return {{32{1'b1}}, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [63:0] s1, res, ra, rb;
    logic [2:0]  rf;
    bit          rw;

    rst = 1; flush = 0; in_valid = 0; in_funct3 = 3'd0; in_word = 0;
    in_src1 = 64'd0; in_src2 = 64'd0; in_tag = '0; out_ready = 0;
    mdu_ready = 0; mdu_result = 64'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 0;

    // mulw with a 3-cycle MDU
    do_op(3'd0, 1, 64'h0000_0000_7FFF_FFFF, 64'd2, 3, 0, s1, res);
    check_eq("mulw_src1", s1, 64'h0000_0000_7FFF_FFFF);
    check_eq("mulw_res", res, 64'hFFFF_FFFF_FFFF_FFFE);

    // divuw by zero, zero-extended dividend
    do_op(3'd5, 1, 64'hFFFF_FFFF_8000_0000, 64'd0, 2, 0, s1, res);
    check_eq("divuw_src1", s1, 64'h0000_0000_8000_0000);
    check_eq("divuw_res", res, 64'hFFFF_FFFF_FFFF_FFFF);

    // div 7 / -2 twice: second one is a reuse hit
    do_op(3'd4, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 4, 0, s1, res);
    do_op(3'd4, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 4, 0, s1, res);
    check_eq("div_hit_res", res, 64'hFFFF_FFFF_FFFF_FFFD);

    // writeback stall for 5 cycles
    do_op(3'd3, 0, {$urandom, $urandom}, {$urandom, $urandom}, 2, 5, s1, res);

    // flush during BUSY
    do_op(3'd6, 0, 64'd100, 64'd7, 2, 0, s1, res);
    mdu_delay = 6;
    @(negedge clk);
    in_valid = 1; in_funct3 = 3'd6; in_word = 0; in_src1 = -64'sd50; in_src2 = 64'd3; in_tag = 5'd9;
    @(negedge clk);
    in_valid = 0;
    check_eq("flush_busy_sel", sel_v, 8'h40);
    flush = 1;
    @(negedge clk);
    flush = 0;
    check_eq("flush_mdu_flush", mdu_flush, 1);
    check_eq("flush_idle", in_ready, 1);
    check_eq("flush_no_valid", out_valid, 0);
    check_eq("flush_sel", sel_v, 0);
    @(negedge clk);
    check_eq("flush_mdu_flush_1cyc", mdu_flush, 0);
    check_eq("flush_no_valid2", out_valid, 0);
    ref_valid = 0;
    do_op(3'd6, 0, 64'd100, 64'd7, 2, 0, s1, res);
    do_op(3'd6, 0, -64'sd50, 64'd3, 2, 0, s1, res);

    // flush coinciding with a request drops it
    @(negedge clk);
    in_valid = 1; flush = 1; in_funct3 = 3'd0; in_src1 = 64'd3; in_src2 = 64'd4;
    @(negedge clk);
    in_valid = 0; flush = 0;
    check_eq("flush_drop_idle", in_ready, 1);
    check_eq("flush_drop_valid", out_valid, 0);
    check_eq("flush_drop_sel", sel_v, 0);
    ref_valid = 0;
    do_op(3'd6, 0, -64'sd50, 64'd3, 1, 0, s1, res);

    // asynchronous reset while BUSY
    mdu_delay = 5;
    @(negedge clk);
    in_valid = 1; in_funct3 = 3'd1; in_word = 0; in_src1 = 64'd12345; in_src2 = 64'd678; in_tag = 5'd3;
    @(negedge clk);
    in_valid = 0;
    check_eq("busy_before_reset", sel_v, 8'h02);
    #2 rst = 1;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst = 0;
    ref_valid = 0;
    do_op(3'd6, 0, -64'sd50, 64'd3, 1, 0, s1, res);

    // randomized traffic with stray mdu_ready outside BUSY
    stray_en = 1;
    ra = 64'd1; rb = 64'd1; rf = 3'd0; rw = 0;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(3, 0) != 0) begin
        rf = 3'($urandom_range(7, 0));
        rw = 1'($urandom_range(1, 0));
        ra = pick_operand();
        rb = pick_operand();
      end else if (rw) begin
        ra[63:32] = $urandom;
        rb[63:32] = $urandom;
      end
      do_op(rf, rw, ra, rb, $urandom_range(4, 1), $urandom_range(2, 0), s1, res);
    end
    stray_en = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mdu_issue.md
MDU_ISSUE -- requirements
Module: mdu_issue

Interface
REQ-001 SHALL have parameter TAG_W, default 5, meaning the width of the destination-register tag passed through.
REQ-002 SHALL have parameter REUSE_EN, default 1, meaning the last-result reuse path is enabled when 1.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 flush  in  1  pipeline kill; aborts any request in flight.
REQ-006 in_valid / in_ready  in / out  1 / 1  upstream request handshake.
REQ-007 in_funct3  in  3  RV M-extension funct3 (000 mul … 111 remu); in_word  in  1  selects the *W variant.
REQ-008 in_src1, in_src2  in  64  operands; in_tag  in  TAG_W  destination tag.
REQ-009 mdu_mul, mdu_mulh, mdu_mulhu, mdu_mulhsu, mdu_div, mdu_divu, mdu_rem, mdu_remu  out  1 each  one-hot operation select to the MDU.
REQ-010 mdu_src1, mdu_src2  out  64  prepared operands; mdu_flush  out  1  MDU abort.
REQ-011 mdu_result  in  64; mdu_ready  in  1  MDU result valid.
REQ-012 out_valid / out_ready  out / in  1 / 1  downstream writeback handshake.
REQ-013 out_result  out  64; out_tag  out  TAG_W.

Function
REQ-014 SHALL implement states IDLE, BUSY and DONE, with in_ready = (state == IDLE) and out_valid = (state == DONE).
REQ-015 On an accept (in_valid & in_ready) in the cycle the edge is taken, SHALL register the operation, prepared operands and tag.
- Transition to BUSY, or to DONE on a reuse hit or an illegal op.
REQ-016 Operand preparation when in_word = 0 SHALL pass operands unchanged.
REQ-016a Operand preparation when in_word = 1:
- mul and div SHALL sign-extend bits [31:0] of each operand.
- divu, remu and rem SHALL extend [31:0]: zero-extension for divu/remu, sign-extension for rem.
REQ-017 in_word = 1 with funct3 001/010/011 SHALL be treated as illegal.
- No MDU access; transition to DONE with out_result = 0.
REQ-018 In BUSY, SHALL hold exactly one mdu_* select high and mdu_src1/2 stable until mdu_ready is sampled high.
- All selects SHALL be low in IDLE and DONE.
REQ-019 At the BUSY edge where mdu_ready = 1, SHALL capture the result into out_result and transition to DONE.
- Word ops SHALL store mdu_result[31:0] sign-extended to 64 bits.
REQ-020 DONE SHALL hold out_result/out_tag stable until out_ready = 1, then transition to IDLE.
- No new request is accepted in the same cycle.
REQ-021 Latency: minimum accept-to-out_valid is 1 cycle for a hit or illegal op, otherwise (MDU cycles + 1).
REQ-022 Reuse (REUSE_EN = 1): SHALL keep the funct3, word bit and prepared operands of the last MDU-completed op plus its 64-bit result, with a valid bit.
- An accepted request identical in all four fields SHALL go to DONE with the stored result and no MDU access.
REQ-023 flush SHALL take priority over every other event.
- Next state is IDLE; out_valid drops the next cycle.
- The in-flight result is discarded and not stored for reuse.
- mdu_flush SHALL be high for exactly the cycle after flush is sampled while in BUSY.
- The reuse valid bit is cleared.
REQ-024 If flush and in_valid coincide, the request SHALL be dropped (not accepted).
REQ-025 If mdu_ready = 1 is sampled outside BUSY, SHALL ignore it.

Reset
REQ-026 While reset is high, SHALL force the following:
- state = IDLE, so in_ready = 1.
- out_valid = 0, out_result = 0, out_tag = 0.
- all mdu_* selects = 0, mdu_src1/2 = 0, mdu_flush = 0.
- reuse valid bit cleared.
REQ-027 Reset asserted mid-operation SHALL abandon the operation with no output; the first accept after deassertion behaves as from power-up.

Structure
REQ-028 The funct3 encodings, the state enumeration and the 64-bit width constant SHALL reside in the shared core package.
REQ-029 Operand preparation and one-hot decode SHALL form one combinational sub-module named mdu_opprep; the FSM, reuse store and handshakes SHALL live in mdu_issue.

Verification
REQ-030 mulw, src1 = 0x00000000_7FFFFFFF, src2 = 2, MDU model with 3-cycle delay -> mdu_src1 = 0x7FFFFFFF, out_result = 0xFFFFFFFF_FFFFFFFE, out_valid at 4 cycles after accept.
REQ-031 divuw, src1 = 0xFFFFFFFF_80000000, src2 = 0 -> mdu_src1 = 0x00000000_80000000, mdu_divu high, out_result = 0xFFFFFFFF_FFFFFFFF.
REQ-032 div, 7 / -2 accepted twice back-to-back -> second request asserts no mdu_* select, out_result = 0xFFFFFFFF_FFFFFFFD, out_valid 1 cycle after accept.
REQ-033 rem issued, flush pulsed during BUSY -> mdu_flush high for 1 cycle, IDLE next cycle, no out_valid; repeating the same rem is not a reuse hit.
REQ-034 out_ready held low for 5 cycles in DONE -> out_result/out_tag stable and in_ready = 0 throughout; accept possible the cycle after out_ready = 1.
REQ-035 reset asserted in BUSY asynchronously -> all outputs at reset values before the next clock edge.
